// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive control FSM and its neighbouring
// counter, sampler, checker and deserializer stages.
interface uart_rx_fsm_if;
    logic       rx_in;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;

    logic       edge_bit_enable;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       frame_err;

    modport master (
        output rx_in, PAR_EN, prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
        input  edge_bit_enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, frame_err
    );

    modport slave (
        input  rx_in, PAR_EN, prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
        output edge_bit_enable, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, frame_err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: walks start/data/parity/stop bit periods and flags each
// frame as valid (data_valid) or dropped (frame_err).
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StValid  = 3'd5
    } state_e;

    localparam logic [3:0] LastBit = 4'(DATA_WIDTH);

    state_e state_q, state_d;
    logic   par_err_q, par_err_d;
    logic   frame_err_q, frame_err_d;
    logic   bit_done;

    // Last edge of the current bit period.
    assign bit_done = ({1'b0, bus.edge_cnt} == (bus.prescale - 6'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;

    always_comb begin
        state_d             = state_q;
        par_err_d           = par_err_q;
        frame_err_d         = 1'b0;
        bus.edge_bit_enable = 1'b0;
        bus.dat_samp_en     = 1'b0;
        bus.strt_chk_en     = 1'b0;
        bus.par_chk_en      = 1'b0;
        bus.stp_chk_en      = 1'b0;
        bus.deser_en        = 1'b0;
        bus.data_valid      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!bus.rx_in) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                bus.edge_bit_enable = 1'b1;
                bus.dat_samp_en     = 1'b1;
                bus.strt_chk_en     = bit_done;
                if (bit_done) begin
                    state_d = bus.strt_glitch ? StIdle : StData;
                end
            end
            StData: begin
                bus.edge_bit_enable = 1'b1;
                bus.dat_samp_en     = 1'b1;
                bus.deser_en        = bit_done;
                if (bit_done && (bus.bit_cnt == LastBit)) begin
                    state_d = bus.PAR_EN ? StParity : StStop;
                end
            end
            StParity: begin
                bus.edge_bit_enable = 1'b1;
                bus.dat_samp_en     = 1'b1;
                bus.par_chk_en      = bit_done;
                if (bit_done) begin
                    state_d   = StStop;
                    par_err_d = bus.par_err;
                end
            end
            StStop: begin
                bus.edge_bit_enable = 1'b1;
                bus.dat_samp_en     = 1'b1;
                bus.stp_chk_en      = bit_done;
                if (bit_done) begin
                    if (bus.stp_err || par_err_q) begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                    end else begin
                        state_d = StValid;
                    end
                end
            end
            StValid: begin
                bus.data_valid = 1'b1;
                // A low line here is already the next frame's start bit.
                if (!bus.rx_in) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter stage and checks frame outcomes
// and timing through an event scoreboard.
module tb_uart_rx_fsm;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_fsm_if bus ();

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int presc;
        int par_en;
        int par_err;
        int stp_err;
        int glitch;
        int exp_kind;   // 0 none, 1 data_valid, 2 frame_err
        int exp_deser;
        int exp_par;
    } vec_t;

    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    evt_t q[$];
    vec_t vecs[9];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ecnt = 0;
    int bcnt = 0;
    bit en_prev = 1'b0;
    int n_deser, n_par, n_strt, n_stp, n_en;
    int n_both = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int kind);
        evt_t e;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic clear_counts();
        n_deser = 0;
        n_par   = 0;
        n_strt  = 0;
        n_stp   = 0;
        n_en    = 0;
    endtask

    // One clock: advance the counter-stage model, then sample the DUT off the edge.
    task automatic tick();
        @(negedge clk);
        if (!en_prev) begin
            ecnt = 0;
            bcnt = 0;
        end else if (ecnt == int'(bus.prescale) - 1) begin
            ecnt = 0;
            bcnt++;
        end else begin
            ecnt++;
        end
        bus.edge_cnt = 5'(ecnt);
        bus.bit_cnt  = 4'(bcnt);
        #1;
        cyc++;
        en_prev = bus.edge_bit_enable;
        if (bus.edge_bit_enable) n_en++;
        if (bus.deser_en)        n_deser++;
        if (bus.par_chk_en)      n_par++;
        if (bus.strt_chk_en)     n_strt++;
        if (bus.stp_chk_en)      n_stp++;
        if (bus.data_valid && bus.frame_err) n_both++;
        if (bus.data_valid) observe(1);
        if (bus.frame_err)  observe(2);
    endtask

    task automatic run_frame(input vec_t v);
        int s;
        int len;
        bus.prescale    = 6'(v.presc);
        bus.PAR_EN      = v.par_en[0];
        bus.par_err     = v.par_err[0];
        bus.stp_err     = v.stp_err[0];
        bus.strt_glitch = v.glitch[0];
        clear_counts();
        len = (v.glitch != 0) ? v.presc : (10 + v.par_en) * v.presc;
        bus.rx_in = 1'b0;
        s = cyc + 1;
        if (v.exp_kind != 0) q.push_back('{kind: v.exp_kind, cyc: s + len});
        tick();
        tick();
        bus.rx_in = 1'b1;
        repeat (len + 4) tick();
        check("missing_events", q.size(), 0);
        q.delete();
        check("deser_pulses", n_deser, v.exp_deser);
        check("par_chk_pulses", n_par, v.exp_par);
        check("strt_chk_pulses", n_strt, 1);
        check("stp_chk_pulses", n_stp, (v.glitch != 0) ? 0 : 1);
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
    endtask

    function automatic logic [7:0] outs();
        return {bus.edge_bit_enable, bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en,
                bus.stp_chk_en, bus.deser_en, bus.data_valid, bus.frame_err};
    endfunction

    initial begin
        int s;
        //            presc par_en par_err stp_err glitch kind deser par
        vecs[0] = '{8,  0, 0, 0, 0, 1, 8, 0};
        vecs[1] = '{16, 1, 0, 0, 0, 1, 8, 1};
        vecs[2] = '{8,  0, 0, 0, 1, 0, 0, 0};
        vecs[3] = '{16, 1, 1, 0, 0, 2, 8, 1};
        vecs[4] = '{8,  0, 0, 0, 0, 1, 8, 0};   // sticky parity error must not leak
        vecs[5] = '{8,  0, 0, 1, 0, 2, 8, 0};
        vecs[6] = '{32, 0, 0, 0, 0, 1, 8, 0};
        vecs[7] = '{32, 1, 0, 1, 0, 2, 8, 1};
        vecs[8] = '{8,  1, 1, 1, 0, 2, 8, 1};

        rst             = 1'b1;
        bus.rx_in       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.prescale    = 6'd8;
        bus.edge_cnt    = 5'd0;
        bus.bit_cnt     = 4'd0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        #1;
        check("reset_outputs", int'(outs()), 0);
        repeat (3) tick();
        rst = 1'b0;
        clear_counts();
        repeat (10) tick();
        check("idle_enable_cycles", n_en, 0);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Back-to-back: line low during VALID starts the next frame immediately.
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        clear_counts();
        bus.rx_in = 1'b0;
        s = cyc + 1;
        q.push_back('{kind: 1, cyc: s + 80});
        q.push_back('{kind: 1, cyc: s + 161});
        tick();
        tick();
        bus.rx_in = 1'b1;
        while (cyc < s + 80) tick();
        bus.rx_in = 1'b0;
        tick();
        bus.rx_in = 1'b1;
        repeat (90) tick();
        check("b2b_missing_events", q.size(), 0);
        q.delete();
        check("b2b_deser_pulses", n_deser, 16);
        check("b2b_strt_chk_pulses", n_strt, 2);

        // Reset in the middle of DATA.
        clear_counts();
        bus.rx_in = 1'b0;
        tick();
        tick();
        bus.rx_in = 1'b1;
        for (int i = 0; i < 200 && bcnt != 4; i++) tick();
        check("reached_data_bit4", bcnt, 4);
        check("mid_frame_enable", int'(bus.edge_bit_enable), 1);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", int'(outs()), 0);
        repeat (3) tick();
        rst = 1'b0;
        clear_counts();
        repeat (150) tick();
        check("post_reset_enable_cycles", n_en, 0);
        check("post_reset_events", q.size(), 0);
        run_frame(vecs[0]);

        check("valid_and_ferr_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
